// File: rtl/record_packer_pkg.sv
// Shared types for the record_packer -> TestFunction2 path: packed record and packer FSM sections.
// Pure type/constant package; no logic.
package testfunction2_types;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
    } record_t;

    typedef enum logic {
        collect_x = 1'b0,
        collect_y = 1'b1
    } RecordPacker_SECTIONS;

endpackage

// File: rtl/record_packer_fifo.sv
// Small record FIFO with a registered head; a push into an empty FIFO shows on head one edge later.
// No internal overflow guard: the owner only pushes when a slot is free (or a pop frees one).
module record_fifo
    import testfunction2_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  record_t                      push_rec,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count_next,
    output record_t                      head,
    output logic                         head_vld
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    record_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [CW-1:0]    count;
    record_t          head_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ptr_next = pop  ? ptr_inc(rd_ptr) : rd_ptr;
        wr_ptr_next = push ? ptr_inc(wr_ptr) : wr_ptr;
        count_next  = count + CW'(push) - CW'(pop);
        head_next   = head;
        // The slot being written this edge is not in mem yet, so bypass it onto the head.
        if (count_next != '0) begin
            if (push && (wr_ptr == rd_ptr_next))
                head_next = push_rec;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            head     <= '0;
            head_vld <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_next;
            wr_ptr   <= wr_ptr_next;
            count    <= count_next;
            head     <= head_next;
            head_vld <= (count_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_rec;
    end

endmodule

// File: rtl/record_packer.sv
// Packs consecutive word pairs into record_t and queues them; record valid 1 cycle after the y word.
// Backpressure: only the y word stalls (a_in_notify=0) when the FIFO is full; x always lands in x_hold.
module record_packer
    import testfunction2_types::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      a_in,
    input  logic             a_in_sync,
    output logic             a_in_notify,
    output record_t          rec_out,
    input  logic             rec_out_sync,
    output logic             rec_out_notify,
    output logic [CNT_W-1:0] pair_count
);

    localparam int CW = $clog2(DEPTH + 1);

    RecordPacker_SECTIONS section;
    RecordPacker_SECTIONS section_next;
    logic [31:0]          x_hold;
    logic [31:0]          x_hold_next;
    logic                 in_xfer;
    logic                 push;
    logic                 pop;
    record_t              push_rec;
    logic [CW-1:0]        count_next;

    always_comb begin
        section_next = section;
        x_hold_next  = x_hold;
        push         = 1'b0;
        in_xfer      = a_in_notify && a_in_sync;
        pop          = rec_out_notify && rec_out_sync;
        push_rec.x   = x_hold;
        push_rec.y   = a_in;
        case (section)
            collect_x: begin
                if (in_xfer) begin
                    x_hold_next  = a_in;
                    section_next = collect_y;
                end
            end
            collect_y: begin
                if (in_xfer) begin
                    push         = 1'b1;
                    section_next = collect_x;
                end
            end
            default: section_next = collect_x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section     <= collect_x;
            x_hold      <= '0;
            pair_count  <= '0;
            a_in_notify <= 1'b1;
        end else begin
            section     <= section_next;
            x_hold      <= x_hold_next;
            if (push)
                pair_count <= pair_count + CNT_W'(1);
            // Registered from next-state so a y word is never offered a slot that is not there.
            a_in_notify <= !((section_next == collect_y) && (count_next == CW'(DEPTH)));
        end
    end

    record_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_rec   (push_rec),
        .pop        (pop),
        .count_next (count_next),
        .head       (rec_out),
        .head_vld   (rec_out_notify)
    );

endmodule
